// File: rtl/debounce_multi.sv
// N-channel push-button conditioner: shared sample tick, two-flop synchroniser,
// per-channel debounce with press/release strobes and long-press detection.
`default_nettype none

module debounce_multi #(
  parameter int CLK_HZ       = 50000000,
  parameter int TICK_HZ      = 9600,
  parameter int N_CH         = 4,
  parameter int STABLE_TICKS = 4,
  parameter int LONG_TICKS   = 9600,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic            src_clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb_in,
  output logic [N_CH-1:0] pb_level,
  output logic [N_CH-1:0] pb_press,
  output logic [N_CH-1:0] pb_release,
  output logic [N_CH-1:0] pb_long,
  output logic [N_CH-1:0] pb_held
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = $clog2(STABLE_TICKS + 1);
  localparam int HW       = $clog2(LONG_TICKS + 1);

  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0]   STAB_LAST = SW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0]   HOLD_SAT  = HW'(LONG_TICKS);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(LONG_TICKS - 1);
  localparam logic [N_CH-1:0] INACTIVE  = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

  logic [TW-1:0]   tickCnt_q, tickCnt_d;
  logic            tick;

  logic [N_CH-1:0] syncA_q, syncB_q;
  logic [N_CH-1:0] act;

  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] press_q, press_d;
  logic [N_CH-1:0] release_q, release_d;
  logic [N_CH-1:0] long_q, long_d;
  logic [N_CH-1:0] held_q, held_d;

  logic [SW-1:0]   stab_q [N_CH];
  logic [SW-1:0]   stab_d [N_CH];
  logic [HW-1:0]   hold_q [N_CH];
  logic [HW-1:0]   hold_d [N_CH];

  // Shared clock-enable: one cycle in every TICK_DIV.
  always_comb begin
    tick      = (tickCnt_q == TICK_LAST);
    tickCnt_d = tick ? '0 : tickCnt_q + TW'(1);
  end

  assign act = syncB_q ^ INACTIVE;

  // Strobes default low every cycle; all other state only moves on a tick.
  always_comb begin
    level_d   = level_q;
    held_d    = held_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int i = 0; i < N_CH; i++) begin
      stab_d[i] = stab_q[i];
      hold_d[i] = hold_q[i];
    end

    if (tick) begin
      for (int i = 0; i < N_CH; i++) begin
        if (act[i] == level_q[i]) begin
          stab_d[i] = '0;
        end else if (stab_q[i] == STAB_LAST) begin
          stab_d[i]  = '0;
          level_d[i] = act[i];
          if (act[i]) begin
            press_d[i] = 1'b1;
          end else begin
            release_d[i] = 1'b1;
          end
        end else begin
          stab_d[i] = stab_q[i] + SW'(1);
        end

        // A falling level wins over hold counting on the same tick.
        if (release_d[i]) begin
          hold_d[i] = '0;
          held_d[i] = 1'b0;
        end else if (level_q[i] && (hold_q[i] != HOLD_SAT)) begin
          hold_d[i] = hold_q[i] + HW'(1);
          if (hold_q[i] == HOLD_LAST) begin
            long_d[i] = 1'b1;
            held_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      tickCnt_q <= '0;
      syncA_q   <= INACTIVE;
      syncB_q   <= INACTIVE;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      held_q    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        stab_q[i] <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      tickCnt_q <= tickCnt_d;
      syncA_q   <= pb_in;
      syncB_q   <= syncA_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      held_q    <= held_d;
      for (int i = 0; i < N_CH; i++) begin
        stab_q[i] <= stab_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign pb_level   = level_q;
  assign pb_press   = press_q;
  assign pb_release = release_q;
  assign pb_long    = long_q;
  assign pb_held    = held_q;

endmodule

`default_nettype wire

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: table of {pins, cycles, expected outputs}
// rows plus a hand-written asynchronous reset sequence.
`timescale 1ns/1ps

module tb_debounce_multi;

  localparam int N = 2;

  logic         src_clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] pb_in;
  logic [N-1:0] pb_level, pb_press, pb_release, pb_long, pb_held;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0] pbIn;
    int           cycles;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
    logic [N-1:0] held;
  } vec_t;

  vec_t vecs[$];

  debounce_multi #(
    .CLK_HZ(100), .TICK_HZ(10), .N_CH(N),
    .STABLE_TICKS(4), .LONG_TICKS(8), .ACTIVE_LOW(1)
  ) dut (
    .src_clk   (src_clk),
    .rst_n     (rst_n),
    .pb_in     (pb_in),
    .pb_level  (pb_level),
    .pb_press  (pb_press),
    .pb_release(pb_release),
    .pb_long   (pb_long),
    .pb_held   (pb_held)
  );

  always #5 src_clk = ~src_clk;

  function automatic vec_t mk(input logic [N-1:0] pbIn, input int cycles,
                              input logic [N-1:0] level, input logic [N-1:0] press,
                              input logic [N-1:0] rel, input logic [N-1:0] lng,
                              input logic [N-1:0] held);
    vec_t v;
    v.pbIn   = pbIn;
    v.cycles = cycles;
    v.level  = level;
    v.press  = press;
    v.rel    = rel;
    v.lng    = lng;
    v.held   = held;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive the pins, run the row's cycles counting strobe-high samples per
  // channel, then compare final levels and strobe counts (expected 0 or 1).
  task automatic applyStimulus(input vec_t v, input string tag);
    int pc[N];
    int rc[N];
    int lc[N];
    for (int ch = 0; ch < N; ch++) begin
      pc[ch] = 0;
      rc[ch] = 0;
      lc[ch] = 0;
    end
    pb_in = v.pbIn;
    repeat (v.cycles) begin
      @(negedge src_clk);
      for (int ch = 0; ch < N; ch++) begin
        pc[ch] += int'(pb_press[ch]);
        rc[ch] += int'(pb_release[ch]);
        lc[ch] += int'(pb_long[ch]);
      end
    end
    checkOutput({tag, " level"}, 32'(pb_level), 32'(v.level));
    checkOutput({tag, " held"},  32'(pb_held),  32'(v.held));
    for (int ch = 0; ch < N; ch++) begin
      checkOutput($sformatf("%s press ch%0d", tag, ch),   32'(pc[ch]), 32'(v.press[ch]));
      checkOutput($sformatf("%s release ch%0d", tag, ch), 32'(rc[ch]), 32'(v.rel[ch]));
      checkOutput($sformatf("%s long ch%0d", tag, ch),    32'(lc[ch]), 32'(v.lng[ch]));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " level"},   32'(pb_level),   32'd0);
    checkOutput({tag, " press"},   32'(pb_press),   32'd0);
    checkOutput({tag, " release"}, 32'(pb_release), 32'd0);
    checkOutput({tag, " long"},    32'(pb_long),    32'd0);
    checkOutput({tag, " held"},    32'(pb_held),    32'd0);
  endtask

  initial begin
    // Edge numbers in the comments count posedges after reset release;
    // ticks land on edges 10, 20, 30, ...
    vecs.push_back(mk(2'b11, 60, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    for (int k = 0; k < 12; k++) begin
      vecs.push_back(mk((k % 2 == 0) ? 2'b10 : 2'b11, 25,
                        2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    end
    // ch0 clean press from edge 360: qualifies on tick 400.
    vecs.push_back(mk(2'b10, 39, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(2'b10,  1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(2'b10,  1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    // ch0 release from edge 401: falls on tick 440, before any long press.
    vecs.push_back(mk(2'b11, 38, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(2'b11,  1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk(2'b11,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    // ch1 long press: press on 480, long on 560, then 50 saturated ticks.
    vecs.push_back(mk(2'b01, 38, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(2'b01,  1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(2'b01, 79, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(2'b01,  1, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10));
    vecs.push_back(mk(2'b01, 500, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10));
    // ch1 release from edge 1060: falls on 1100 together with held.
    vecs.push_back(mk(2'b11, 39, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10));
    vecs.push_back(mk(2'b11,  1, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00));
    vecs.push_back(mk(2'b11,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    // ch1 pressed again: press on 1140, long on 1220, still held at 1230.
    vecs.push_back(mk(2'b01, 129, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10));

    rst_n = 1'b0;
    pb_in = 2'b00;
    repeat (3) @(negedge src_clk);
    checkAllZero("reset pins00");
    pb_in = 2'b11;
    @(negedge src_clk);
    checkAllZero("reset pins11");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], $sformatf("row%0d", i));
    end

    // Asynchronous reset between edges while ch1 is held; ch0 goes down too.
    @(posedge src_clk);
    #3;
    rst_n = 1'b0;
    pb_in = 2'b00;
    #1;
    checkAllZero("async reset");
    repeat (2) @(negedge src_clk);
    checkAllZero("in reset");
    rst_n = 1'b1;

    // Both channels re-qualify together on tick 40 after release.
    applyStimulus(mk(2'b00, 39, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "requal wait");
    applyStimulus(mk(2'b00,  1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00), "requal press");
    applyStimulus(mk(2'b11, 39, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00), "both rel wait");
    applyStimulus(mk(2'b11,  1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00), "both rel");
    applyStimulus(mk(2'b11,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "both idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised N-channel push-button conditioner; the next generation of the single-channel GPIO debouncer.
- Runs entirely on the system clock. The sample rate comes from an internal clock-enable tick; no derived clocks are generated.
- Per channel it provides:
  - a synchronised, polarity-normalised, debounced level;
  - one-cycle press and release strobes;
  - a long-press strobe and flag.
- Sits between the board pins and the UART/control logic.

Parameters:
- CLK_HZ, 50000000, source clock frequency in Hz.
- TICK_HZ, 9600, sample tick rate. TICK_DIV = CLK_HZ/TICK_HZ must be >= 2.
- N_CH, 4, number of independent input channels.
- STABLE_TICKS, 4, consecutive differing samples required to accept a new level. Must be >= 1.
- LONG_TICKS, 9600, ticks the level must stay active before the long-press event fires. Must be >= 1.
- ACTIVE_LOW, 1, 1 means the pin reads 0 when pressed. Applies to all channels.

Ports:
- src_clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pb_in  in  N_CH  raw asynchronous button pins.
- pb_level  out  N_CH  debounced level; 1 = pressed.
- pb_press  out  N_CH  one-cycle strobe when pb_level rises.
- pb_release  out  N_CH  one-cycle strobe when pb_level falls.
- pb_long  out  N_CH  one-cycle strobe when the long-press threshold is reached.
- pb_held  out  N_CH  level flag: long press reached and button still pressed.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs go to 0.
  - Tick counter, stability counters and hold counters go to 0.
  - Synchroniser flops go to the inactive pin level (ACTIVE_LOW ? 1 : 0).
  - Deassertion takes effect on the next src_clk edge.
  - Reset mid-press clears pb_level with no release strobe. After reset a still-pressed button must re-qualify.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick = 1 for exactly one cycle when the counter equals TICK_DIV-1; the counter starts at 0 after reset.
  - Width is $clog2(TICK_DIV).
- Synchroniser: two flops per channel. act[i] = sync2[i] XOR ACTIVE_LOW.
- Per-channel debounce. State is only evaluated on tick cycles; between ticks all state holds.
  - act[i] == pb_level[i]: stability counter cleared to 0. This covers bounce shorter than STABLE_TICKS samples.
  - act[i] != pb_level[i] and counter == STABLE_TICKS-1: pb_level toggles on that edge, counter cleared to 0.
    - Rising toggle: pb_press asserted for one cycle.
    - Falling toggle: pb_release asserted for one cycle.
  - Otherwise: counter increments.
  - Counter width is $clog2(STABLE_TICKS+1). It never exceeds STABLE_TICKS-1.
- Long press:
  - The hold counter increments on each tick while pb_level=1, and saturates at LONG_TICKS.
  - On the tick where it becomes LONG_TICKS: pb_long strobes for one cycle and pb_held sets.
  - Neither fires again while saturated.
  - When pb_level falls: hold counter clears to 0 and pb_held clears on the same edge that pulses pb_release.
- Strobe timing:
  - Strobes coincide with the pb_level transition edge and are registered.
  - pb_press and pb_long may coincide only if LONG_TICKS = 0, which is disallowed. So pb_long always occurs at least one tick after pb_press.
- Latency: a clean pin edge reaches pb_level after 2 sync cycles + wait to the next tick + (STABLE_TICKS-1) ticks.
  - Worst case: 2 + STABLE_TICKS*TICK_DIV cycles.
- Independence: channels share only the tick. Simultaneous events on several channels are all reported in the same cycle.

Test Plan:
(sim params: CLK_HZ=100, TICK_HZ=10, N_CH=2, STABLE_TICKS=4, LONG_TICKS=8, ACTIVE_LOW=1)
- Reset check: hold rst_n=0 with pb_in=2'b00 → all outputs 0. Release reset with pb_in=2'b11 → outputs stay 0 indefinitely; tick period is 10 cycles.
- Clean press on ch0:
  - Drive pb_in[0]=0 and hold.
  - pb_level[0] rises on the 4th tick after sync, within 42 cycles.
  - pb_press[0] is high for exactly 1 cycle; ch1 stays 0.
- Bounce rejection: toggle pb_in[0] every 25 cycles (2–3 ticks per state) for 300 cycles → pb_level[0] never changes, no strobes.
- Release: after the press, set pb_in[0]=1 → pb_level[0] falls after 4 ticks, pb_release[0] strobes once.
- Long press:
  - Hold ch1 pressed.
  - pb_long[1] strobes once, 8 ticks after pb_press[1], and pb_held[1]=1.
  - Keep holding 50 more ticks → no further pb_long.
  - Release → pb_held[1] clears with pb_release[1].
- Async reset mid-operation: assert rst_n=0 between clock edges while ch1 is held → outputs clear immediately. Deassert with the button still down → pb_press[1] recurs after 4 ticks.
